sram_like_responder: RTL and testbench

//   Slave end of the SRAM-like bus used by the core's inst/data ports.

---
 rtl/sram_like_responder_if.sv | 24 ++
 rtl/sram_like_responder.sv | 96 +++++++++
 tb/tb_sram_like_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_responder_if.sv
// SRAM-like bus between a core port (master) and a memory responder (slave).
// Carries the request/accept handshake, write payload and in-order responses.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata, stall,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, stall,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// Memory model behind an SRAM-like port: queues accepted requests and
// answers them in order after a minimum latency from a local word RAM.
module sram_like_responder #(
    parameter int MEM_AW   = 10,
    parameter int QDEPTH   = 4,
    parameter int DATA_LAT = 2
) (
    input logic clk,
    input logic reset,
    sram_like_responder_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int WW = $clog2(DATA_LAT + 1);

    logic [31:0]       mem_q [0:(1 << MEM_AW) - 1];
    logic [QDEPTH-1:0] valid_q;
    logic [QDEPTH-1:0] ewr_q;
    logic [31:0]       edata_q [QDEPTH];
    logic [WW-1:0]     ewait_q [QDEPTH];

    logic [PW:0]       head_q, head_d;
    logic [PW:0]       tail_q, tail_d;
    logic [PW:0]       count;
    logic [PW-1:0]     hidx, tidx;
    logic [MEM_AW-1:0] idx;
    logic              addr_ok, push, pop;
    logic              data_ok_q;
    logic [31:0]       rdata_q;
    logic              unused_bits;

    assign hidx  = head_q[PW-1:0];
    assign tidx  = tail_q[PW-1:0];
    assign count = tail_q - head_q;
    assign idx   = bus.addr[MEM_AW+1:2];

    assign addr_ok = ~reset & ~bus.stall & (count < (PW+1)'(QDEPTH));
    assign push    = bus.req & addr_ok;
    assign pop     = valid_q[hidx] & (ewait_q[hidx] == '0);

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    // size is informational and the byte offset/upper bits alias away
    assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:MEM_AW+2]};

    // Pointer advance: one push and one pop at most per cycle
    always_comb begin
        head_d = head_q + {{PW{1'b0}}, pop};
        tail_d = tail_q + {{PW{1'b0}}, push};
    end

    // RAM byte writes land on the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        if (push && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Queue entries, latency countdown and the registered response stage
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            valid_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < QDEPTH; i++) begin
                if (valid_q[i] && ewait_q[i] != '0) begin
                    ewait_q[i] <= ewait_q[i] - 1'b1;
                end
            end
            if (pop) begin
                valid_q[hidx] <= 1'b0;
                data_ok_q     <= 1'b1;
                rdata_q       <= ewr_q[hidx] ? 32'h0 : edata_q[hidx];
            end else begin
                data_ok_q <= 1'b0;
                rdata_q   <= 32'h0;
            end
            if (push) begin
                valid_q[tidx] <= 1'b1;
                ewr_q[tidx]   <= bus.wr;
                edata_q[tidx] <= mem_q[idx];
                ewait_q[tidx] <= WW'(DATA_LAT - 1);
            end
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder with QDEPTH=4, DATA_LAT=4.
// Each scenario task drives the bus and checks its own expectations.
module tb_sram_like_responder;
    localparam int QD  = 4;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_like_responder_if bus ();

    sram_like_responder #(
        .MEM_AW  (10),
        .QDEPTH  (QD),
        .DATA_LAT(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int dok_cnt = 0;
    int max_out = 0;
    int          acc_edge[$];
    logic [31:0] resp_data[$];
    int          resp_edge[$];

    // Accept monitor: edge index of every req&addr_ok
    always @(posedge clk) begin
        if (bus.req && bus.addr_ok) begin
            acc_cnt++;
            acc_edge.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Response monitor: data and the edge that produced it
    always @(negedge clk) begin
        if (bus.data_ok === 1'b1) begin
            dok_cnt++;
            resp_data.push_back(bus.rdata);
            resp_edge.push_back(cyc - 1);
        end
        if (acc_cnt - dok_cnt > max_out) max_out = acc_cnt - dok_cnt;
    end

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output int edge_o, output bit ok);
        int start;
        start = acc_cnt;
        ok = 1'b0;
        edge_o = -1;
        bus.req = 1'b1;
        bus.wr = w;
        bus.addr = a;
        bus.wdata = d;
        bus.wstrb = s;
        bus.size = 2'd2;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (acc_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        bus.req = 1'b0;
        if (ok) edge_o = acc_edge[$];
    endtask

    task automatic burst(input int n, input logic [31:0] base,
                         output int got, output logic aok4);
        int start;
        start = acc_cnt;
        aok4 = 1'bx;
        got = 0;
        bus.req = 1'b1;
        bus.wr = 1'b0;
        bus.addr = base;
        bus.wstrb = 4'h0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (acc_cnt - start == QD && aok4 === 1'bx) aok4 = bus.addr_ok;
            got = acc_cnt - start;
            if (got >= n) break;
            bus.addr = base + 32'(4 * got);
        end
        bus.req = 1'b0;
    endtask

    task automatic wait_resp(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (resp_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_resp();
        resp_data.delete();
        resp_edge.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 1'b1;
        bus.wr = 1'b1;
        bus.addr = 32'h1C;
        bus.wdata = 32'h1234_5678;
        bus.wstrb = 4'hF;
        bus.size = 2'd2;
        bus.stall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.addr_ok !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_addr_ok: got %b want 0", bus.addr_ok);
            end
            n_cmp++;
            if (bus.data_ok !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_data_ok: got %b want 0", bus.data_ok);
            end
            n_cmp++;
            if (bus.rdata !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_rdata: got %h want 0", bus.rdata);
            end
        end
        n_cmp++;
        if (acc_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_no_accept: got %0d want 0", acc_cnt);
        end
        bus.req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.addr_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_addr_ok: got %b want 1", bus.addr_ok);
        end
    endtask

    task automatic test_write_read();
        int ew, er;
        bit ok, ok2;
        clear_resp();
        issue(1'b1, 32'h1C, 32'hDEAD_BEEF, 4'hF, ew, ok);
        wait_resp(1, ok2);
        n_cmp++;
        if (!ok2 || resp_data[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL wr_resp_rdata: got %h want 0 (seen %0b)",
                     ok2 ? resp_data[0] : 32'hx, ok2);
        end
        n_cmp++;
        if (!ok2 || resp_edge[0] - ew !== LAT) begin
            n_bad++;
            $display("FAIL wr_latency: got %0d want %0d",
                     ok2 ? resp_edge[0] - ew : -1, LAT);
        end
        issue(1'b0, 32'h1C, 32'h0, 4'h0, er, ok);
        wait_resp(2, ok2);
        n_cmp++;
        if (!ok2 || resp_data[1] !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL rd_word: got %h want deadbeef",
                     ok2 ? resp_data[1] : 32'hx);
        end
        n_cmp++;
        if (!ok2 || resp_edge[1] - er !== LAT) begin
            n_bad++;
            $display("FAIL rd_latency: got %0d want %0d",
                     ok2 ? resp_edge[1] - er : -1, LAT);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] addrs [3];
        int e;
        bit ok, ok2;
        addrs[0] = 32'h0000_001C;
        addrs[1] = 32'h0000_101C;
        addrs[2] = 32'h0000_001F;
        clear_resp();
        issue(1'b1, 32'h1C, 32'h0000_AA00, 4'b0010, e, ok);
        for (int i = 0; i < 3; i++) issue(1'b0, addrs[i], 32'h0, 4'h0, e, ok);
        wait_resp(4, ok2);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (!ok2 || resp_data[i+1] !== 32'hDEAD_AAEF) begin
                n_bad++;
                $display("FAIL byte_rd[%0d] addr %h: got %h want deadaaef",
                         i, addrs[i], ok2 ? resp_data[i+1] : 32'hx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, got, first;
        bit ok, ok2;
        logic aok4;
        clear_resp();
        for (int k = 0; k < 6; k++) begin
            issue(1'b1, 32'h100 + 32'(4 * k), 32'hA500_0000 + 32'(k),
                  4'hF, e, ok);
        end
        wait_resp(6, ok2);
        repeat (2) @(negedge clk);
        clear_resp();
        max_out = 0;
        first = acc_edge.size();
        burst(6, 32'h100, got, aok4);
        n_cmp++;
        if (got !== 6) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d want 6", got);
        end
        n_cmp++;
        if (aok4 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_full_addr_ok: got %b want 0", aok4);
        end
        wait_resp(6, ok2);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (!ok2 || resp_data[k] !== 32'hA500_0000 + 32'(k)) begin
                n_bad++;
                $display("FAIL b2b_data[%0d]: got %h want %h", k,
                         ok2 ? resp_data[k] : 32'hx, 32'hA500_0000 + 32'(k));
            end
        end
        n_cmp++;
        if (got < 6 || acc_edge[first+4] - acc_edge[first] !== 5) begin
            n_bad++;
            $display("FAIL b2b_5th_accept: got %0d want 5",
                     got < 6 ? -1 : acc_edge[first+4] - acc_edge[first]);
        end
        n_cmp++;
        if (!ok2 || got < 6 || resp_edge[0] - acc_edge[first] !== LAT) begin
            n_bad++;
            $display("FAIL b2b_first_latency: want %0d", LAT);
        end
        n_cmp++;
        if (!ok2 || resp_edge[3] - resp_edge[0] !== 3
                 || resp_edge[5] - resp_edge[0] !== 6) begin
            n_bad++;
            $display("FAIL b2b_resp_spacing: got %0d/%0d want 3/6",
                     ok2 ? resp_edge[3] - resp_edge[0] : -1,
                     ok2 ? resp_edge[5] - resp_edge[0] : -1);
        end
        n_cmp++;
        if (max_out > QD || max_out < QD) begin
            n_bad++;
            $display("FAIL b2b_outstanding: got %0d want %0d", max_out, QD);
        end
    endtask

    task automatic test_stall();
        int start, exp_edge;
        bit ok2;
        clear_resp();
        start = acc_cnt;
        bus.stall = 1'b1;
        bus.req = 1'b1;
        bus.wr = 1'b0;
        bus.addr = 32'h1C;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (bus.addr_ok !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_addr_ok: got %b want 0", bus.addr_ok);
            end
        end
        n_cmp++;
        if (acc_cnt !== start) begin
            n_bad++;
            $display("FAIL stall_no_accept: got %0d want 0", acc_cnt - start);
        end
        bus.stall = 1'b0;
        exp_edge = cyc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_cnt != start) break;
        end
        bus.req = 1'b0;
        n_cmp++;
        if (acc_cnt == start || acc_edge[$] !== exp_edge) begin
            n_bad++;
            $display("FAIL stall_release_edge: got %0d want %0d",
                     acc_cnt == start ? -1 : acc_edge[$], exp_edge);
        end
        wait_resp(1, ok2);
        n_cmp++;
        if (!ok2 || resp_data[0] !== 32'hDEAD_AAEF) begin
            n_bad++;
            $display("FAIL stall_rdata: got %h want deadaaef",
                     ok2 ? resp_data[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        int got, e;
        bit ok, ok2;
        logic aok4;
        repeat (10) @(negedge clk);
        clear_resp();
        burst(3, 32'h100, got, aok4);
        reset = 1'b1;
        n_cmp++;
        if (got !== 3) begin
            n_bad++;
            $display("FAIL mid_accepts: got %0d want 3", got);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (bus.data_ok !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_reset_data_ok: got %b want 0", bus.data_ok);
            end
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (resp_data.size() !== 0) begin
            n_bad++;
            $display("FAIL mid_dropped: got %0d responses want 0",
                     resp_data.size());
        end
        issue(1'b0, 32'h1C, 32'h0, 4'h0, e, ok);
        wait_resp(1, ok2);
        n_cmp++;
        if (!ok2 || resp_data[0] !== 32'hDEAD_AAEF) begin
            n_bad++;
            $display("FAIL mid_ram_kept: got %h want deadaaef",
                     ok2 ? resp_data[0] : 32'hx);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 1'b0;
        bus.wr = 1'b0;
        bus.size = 2'd2;
        bus.wstrb = 4'h0;
        bus.addr = 32'h0;
        bus.wdata = 32'h0;
        bus.stall = 1'b0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
